img_host_frontend: RTL and testbench



---
 rtl/img_host_frontend.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_img_host_frontend.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_host_frontend.sv
// Host byte-stream front-end for the image-convolution core: parses command bytes,
// paces pixel uploads through an input FIFO and collects core output into an output FIFO.

package img_host_pkg;
  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_SET_NROWS = 4'd1,
    OP_SET_NCOLS = 4'd2,
    OP_SET_SIGMA = 4'd3,
    OP_GET_NROWS = 4'd4,
    OP_GET_NCOLS = 4'd5,
    OP_GET_SIGMA = 4'd6,
    OP_IMG_RX    = 4'd7,
    OP_IMG_TX    = 4'd8,
    OP_CONV      = 4'd9
  } opcode_t;
endpackage

module img_host_frontend
  import img_host_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PREFILL    = 8,
  parameter int unsigned TX_CAP_LAT = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic       core_en,
  output opcode_t    core_op,
  output logic [7:0] core_din,
  input  logic [7:0] core_dout,
  input  logic       core_busy,
  output logic       err_underrun,
  output logic       err_overflow,
  output logic       err_badcmd,
  input  logic       err_clr,
  output logic       idle
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] PrefillLen  = 16'(PREFILL);
  localparam logic [7:0]  CapWaitInit = 8'(TX_CAP_LAT - 1);

  typedef enum logic [3:0] {
    StIdle, StArg, StSetIssue, StGetIssue, StRxFill, StRxRun,
    StTxIssue, StConvIssue, StWaitFirst, StWaitDone
  } state_e;

  state_e        state_q, state_d;
  opcode_t       cmd_q, cmd_d;
  logic [7:0]    arg_q, arg_d;
  logic [7:0]    nrows_q, nrows_d, ncols_q, ncols_d;
  logic [15:0]   pix_q, pix_d;
  logic          get_cap_q, get_cap_d;
  logic [7:0]    cap_wait_q, cap_wait_d;
  logic [15:0]   cap_left_q, cap_left_d;
  logic          err_underrun_q, err_underrun_d;
  logic          err_overflow_q, err_overflow_d;
  logic          err_badcmd_q, err_badcmd_d;
  logic          live_q;

  logic [7:0]    in_mem_q [FIFO_DEPTH];
  logic [AW-1:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [7:0]    out_mem_q [FIFO_DEPTH];
  logic [AW-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic          in_full, in_empty, out_full, out_empty;
  logic          in_push, in_pop, in_push_ok, in_pop_ok;
  logic          out_push, out_pop, cap_req, cap_fire, cap_start;
  logic          set_badcmd, set_underrun, set_overflow;
  logic          is_get_byte;
  logic [15:0]   npix, fill_thresh;

  assign npix        = {8'd0, nrows_q} * {8'd0, ncols_q};
  assign fill_thresh = (npix < PrefillLen) ? npix : PrefillLen;
  assign in_full     = (in_cnt_q == CW'(FIFO_DEPTH));
  assign in_empty    = (in_cnt_q == '0);
  assign out_full    = (out_cnt_q == CW'(FIFO_DEPTH));
  assign out_empty   = (out_cnt_q == '0);
  assign is_get_byte = (s_data[7:4] == 4'd0) && (s_data[3:0] >= 4'd4) && (s_data[3:0] <= 4'd6);

  assign m_valid      = !out_empty;
  assign m_data       = out_mem_q[out_rptr_q];
  assign idle         = (state_q == StIdle) && in_empty;
  assign err_underrun = err_underrun_q;
  assign err_overflow = err_overflow_q;
  assign err_badcmd   = err_badcmd_q;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    nrows_d      = nrows_q;
    ncols_d      = ncols_q;
    pix_d        = pix_q;
    get_cap_d    = 1'b0;
    s_ready      = 1'b0;
    core_en      = 1'b0;
    core_op      = OP_NOP;
    core_din     = 8'd0;
    in_push      = 1'b0;
    in_pop       = 1'b0;
    cap_start    = 1'b0;
    set_badcmd   = 1'b0;
    set_underrun = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A GET byte is held off until its reply is guaranteed a slot.
        s_ready = live_q && !(is_get_byte && out_full);
        if (s_valid && s_ready) begin
          if (s_data[7:4] != 4'd0 || s_data[3:0] > 4'd9) begin
            set_badcmd = 1'b1;
          end else begin
            case (s_data[3:0])
              4'd1, 4'd2, 4'd3: begin
                cmd_d   = opcode_t'(s_data[3:0]);
                state_d = StArg;
              end
              4'd4, 4'd5, 4'd6: begin
                cmd_d   = opcode_t'(s_data[3:0]);
                state_d = StGetIssue;
              end
              4'd7:    if (npix != 16'd0) state_d = StRxFill;
              4'd8:    if (npix != 16'd0) state_d = StTxIssue;
              4'd9:    state_d = StConvIssue;
              default: ;
            endcase
          end
        end
      end
      StArg: begin
        s_ready = live_q;
        if (s_valid && s_ready) begin
          arg_d   = s_data;
          state_d = StSetIssue;
        end
      end
      StSetIssue: begin
        core_en  = 1'b1;
        core_op  = cmd_q;
        core_din = arg_q;
        if (cmd_q == OP_SET_NROWS) nrows_d = arg_q;
        if (cmd_q == OP_SET_NCOLS) ncols_d = arg_q;
        state_d = StIdle;
      end
      StGetIssue: begin
        core_en   = 1'b1;
        core_op   = cmd_q;
        get_cap_d = 1'b1;
        state_d   = StIdle;
      end
      StRxFill: begin
        s_ready = live_q && !in_full;
        in_push = s_valid && s_ready;
        if (16'(in_cnt_q) >= fill_thresh) begin
          core_en = 1'b1;
          core_op = OP_IMG_RX;
          pix_d   = 16'd0;
          state_d = StRxRun;
        end
      end
      StRxRun: begin
        s_ready = live_q && !in_full;
        in_push = s_valid && s_ready;
        // An empty slot still consumes a pixel position; the core sees zero.
        if (in_empty) begin
          set_underrun = 1'b1;
        end else begin
          in_pop   = 1'b1;
          core_din = in_mem_q[in_rptr_q];
        end
        pix_d = pix_q + 16'd1;
        if (pix_q == npix - 16'd1) state_d = StWaitFirst;
      end
      StTxIssue: begin
        core_en   = 1'b1;
        core_op   = OP_IMG_TX;
        cap_start = 1'b1;
        state_d   = StWaitFirst;
      end
      StConvIssue: begin
        core_en = 1'b1;
        core_op = OP_CONV;
        state_d = StWaitFirst;
      end
      // The core may not have raised busy yet in the cycle after the strobe.
      StWaitFirst: state_d = StWaitDone;
      StWaitDone:  if (!core_busy) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Output capture engine for IMG_TX, independent of the command FSM.
  always_comb begin
    cap_wait_d = cap_wait_q;
    cap_left_d = cap_left_q;
    cap_fire   = 1'b0;
    if (cap_start) begin
      cap_wait_d = CapWaitInit;
      cap_left_d = npix;
    end else if (cap_left_q != 16'd0) begin
      if (cap_wait_q != 8'd0) begin
        cap_wait_d = cap_wait_q - 8'd1;
      end else begin
        cap_fire   = 1'b1;
        cap_left_d = cap_left_q - 16'd1;
      end
    end
  end

  always_comb begin
    in_push_ok   = in_push && (!in_full || in_pop);
    in_pop_ok    = in_pop && !in_empty;
    in_wptr_d    = in_wptr_q + AW'(in_push_ok);
    in_rptr_d    = in_rptr_q + AW'(in_pop_ok);
    in_cnt_d     = in_cnt_q + CW'(in_push_ok) - CW'(in_pop_ok);
    out_pop      = m_ready && !out_empty;
    cap_req      = cap_fire || get_cap_q;
    out_push     = cap_req && (!out_full || out_pop);
    set_overflow = cap_req && !out_push;
    out_wptr_d   = out_wptr_q + AW'(out_push);
    out_rptr_d   = out_rptr_q + AW'(out_pop);
    out_cnt_d    = out_cnt_q + CW'(out_push) - CW'(out_pop);
    err_underrun_d = (err_underrun_q && !err_clr) || set_underrun;
    err_overflow_d = (err_overflow_q && !err_clr) || set_overflow;
    err_badcmd_d   = (err_badcmd_q && !err_clr) || set_badcmd;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      cmd_q          <= OP_NOP;
      arg_q          <= 8'd0;
      nrows_q        <= 8'd8;
      ncols_q        <= 8'd8;
      pix_q          <= 16'd0;
      get_cap_q      <= 1'b0;
      cap_wait_q     <= 8'd0;
      cap_left_q     <= 16'd0;
      err_underrun_q <= 1'b0;
      err_overflow_q <= 1'b0;
      err_badcmd_q   <= 1'b0;
      live_q         <= 1'b0;
      in_wptr_q      <= '0;
      in_rptr_q      <= '0;
      in_cnt_q       <= '0;
      out_wptr_q     <= '0;
      out_rptr_q     <= '0;
      out_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      arg_q          <= arg_d;
      nrows_q        <= nrows_d;
      ncols_q        <= ncols_d;
      pix_q          <= pix_d;
      get_cap_q      <= get_cap_d;
      cap_wait_q     <= cap_wait_d;
      cap_left_q     <= cap_left_d;
      err_underrun_q <= err_underrun_d;
      err_overflow_q <= err_overflow_d;
      err_badcmd_q   <= err_badcmd_d;
      live_q         <= 1'b1;
      in_wptr_q      <= in_wptr_d;
      in_rptr_q      <= in_rptr_d;
      in_cnt_q       <= in_cnt_d;
      out_wptr_q     <= out_wptr_d;
      out_rptr_q     <= out_rptr_d;
      out_cnt_q      <= out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_push_ok) in_mem_q[in_wptr_q] <= s_data;
    if (out_push) out_mem_q[out_wptr_q] <= core_dout;
  end

endmodule

// File: tb/tb_img_host_frontend.sv
// Directed bench for img_host_frontend with a small behavioural core model
// (shadow registers, GET replies, IMG_TX pixel stream and busy).

module tb_img_host_frontend;
  import img_host_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic       core_en;
  opcode_t    core_op;
  logic [7:0] core_din;
  logic [7:0] core_dout = 8'd0;
  logic       core_busy;
  logic       err_underrun, err_overflow, err_badcmd;
  logic       err_clr = 1'b0;
  logic       idle;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cnt = 0;

  opcode_t    en_op[$];
  logic [7:0] en_din[$];
  int         en_cyc[$];
  int         en_hs[$];
  logic [7:0] din_log [4096];

  logic [7:0] m_nrows = 8'd8;
  logic [7:0] m_ncols = 8'd8;
  logic [7:0] get_val = 8'd0;
  int         tx_off = 0;
  bit         tx_act = 1'b0;
  bit         conv_busy = 1'b0;

  assign core_busy = (tx_act && tx_off < 66) || conv_busy;

  always #5 clk = ~clk;

  img_host_frontend #(.FIFO_DEPTH(16), .PREFILL(8), .TX_CAP_LAT(2)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .core_en(core_en),
    .core_op(core_op), .core_din(core_din), .core_dout(core_dout), .core_busy(core_busy),
    .err_underrun(err_underrun), .err_overflow(err_overflow), .err_badcmd(err_badcmd),
    .err_clr(err_clr), .idle(idle)
  );

  function automatic logic [7:0] tx_pix(input int k);
    return 8'(k * 3 + 7);
  endfunction

  // Monitor and core model; core_dout set here is what the DUT samples at the next posedge.
  always @(negedge clk) begin
    din_log[cyc % 4096] = core_din;
    if (core_en) begin
      en_op.push_back(core_op);
      en_din.push_back(core_din);
      en_cyc.push_back(cyc);
      en_hs.push_back(hs_cnt);
    end
    if (s_valid && s_ready) hs_cnt++;
    if (!rstn) begin
      m_nrows = 8'd8; m_ncols = 8'd8; get_val = 8'd0; tx_act = 1'b0; tx_off = 0;
    end else begin
      if (core_en && core_op == OP_IMG_TX) begin
        tx_act = 1'b1; tx_off = 0;
      end else if (tx_act) begin
        tx_off++;
        if (tx_off >= 70) tx_act = 1'b0;
      end
      if (core_en) begin
        case (core_op)
          OP_SET_NROWS: m_nrows = core_din;
          OP_SET_NCOLS: m_ncols = core_din;
          OP_GET_NROWS: get_val = m_nrows;
          OP_GET_NCOLS: get_val = m_ncols;
          default: ;
        endcase
      end
    end
    core_dout = (tx_act && tx_off >= 2 && tx_off < 66) ? tx_pix(tx_off - 2) : get_val;
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    en_op.delete(); en_din.delete(); en_cyc.delete(); en_hs.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0; err_clr = 1'b0; conv_busy = 1'b0;
    step(); step();
    rstn = 1'b1;
    step(); step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    s_valid = 1'b1; s_data = b;
    sample();
    while (!s_ready && t < 1000) begin sample(); t++; end
    if (!s_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte_timeout: byte %02h s_ready=%0b required 1", b, s_ready);
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    sample();
    while (!idle && t < budget) begin sample(); t++; end
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++; $display("FAIL wait_idle: idle=%0b required 1 after %0d cycles", idle, budget);
    end
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    sample();
    n_checks++;
    if ({core_en, core_din, s_ready, m_valid, err_underrun, err_overflow, err_badcmd, idle}
        !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: en=%0b din=%02h rdy=%0b mv=%0b err=%0b%0b%0b idle=%0b required 0 00 0 0 000 1",
               core_en, core_din, s_ready, m_valid, err_underrun, err_overflow, err_badcmd, idle);
    end
    n_checks++;
    if (core_op !== OP_NOP) begin n_fail++; $display("FAIL reset_op: got %0d required 0", core_op); end
    step();
    rstn = 1'b1;
    step(); step();
    sample();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %0b required 1", s_ready); end
    step();
  endtask

  task automatic test_set_get();
    int t = 0;
    do_reset(); clear_logs();
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h02); send_byte(8'h20);
    step(); step(); step();
    n_checks++;
    if (en_op.size() != 2) begin n_fail++; $display("FAIL set_count: got %0d required 2", en_op.size()); end
    if (en_op.size() >= 2) begin
      n_checks++;
      if (en_op[0] !== OP_SET_NROWS || en_din[0] !== 8'h10) begin
        n_fail++; $display("FAIL set_nrows: got op %0d din %02h required 1 10", en_op[0], en_din[0]);
      end
      n_checks++;
      if (en_op[1] !== OP_SET_NCOLS || en_din[1] !== 8'h20) begin
        n_fail++; $display("FAIL set_ncols: got op %0d din %02h required 2 20", en_op[1], en_din[1]);
      end
    end
    send_byte(8'h04);
    sample();
    while (!m_valid && t < 20) begin sample(); t++; end
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h10) begin
      n_fail++; $display("FAIL get_nrows: got valid %0b data %02h required 1 10", m_valid, m_data);
    end
    n_checks++;
    if (en_op.size() != 3 || en_op[en_op.size()-1] !== OP_GET_NROWS) begin
      n_fail++; $display("FAIL get_strobe: got %0d strobes required 3 ending in GET_NROWS", en_op.size());
    end
    step(); m_ready = 1'b1; step(); m_ready = 1'b0;
    sample();
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL get_pop: m_valid=%0b required 0", m_valid); end
    step();
  endtask

  task automatic test_rx_full();
    int hs0;
    do_reset(); clear_logs();
    hs0 = hs_cnt;
    send_byte(8'h07);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    wait_idle(500);
    n_checks++;
    if (en_op.size() != 1 || en_op[0] !== OP_IMG_RX) begin
      n_fail++; $display("FAIL rx_strobe: got %0d strobes required 1 IMG_RX", en_op.size());
    end
    if (en_op.size() == 1) begin
      n_checks++;
      if (en_hs[0] - hs0 != 9) begin
        n_fail++; $display("FAIL rx_prefill: strobe after %0d bytes required 9", en_hs[0] - hs0);
      end
      for (int k = 0; k < 64; k++) begin
        n_checks++;
        if (din_log[(en_cyc[0] + 1 + k) % 4096] !== 8'(k)) begin
          n_fail++;
          $display("FAIL rx_slot%0d: got %02h required %02h", k, din_log[(en_cyc[0]+1+k) % 4096], 8'(k));
        end
      end
    end
    n_checks++;
    if (err_underrun !== 1'b0) begin n_fail++; $display("FAIL rx_no_underrun: got %0b required 0", err_underrun); end
  endtask

  task automatic test_rx_underrun();
    do_reset(); clear_logs();
    send_byte(8'h07);
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    wait_idle(500);
    if (en_cyc.size() == 1) begin
      for (int k = 0; k < 64; k++) begin
        n_checks++;
        if (din_log[(en_cyc[0] + 1 + k) % 4096] !== ((k < 20) ? 8'(k) : 8'h00)) begin
          n_fail++;
          $display("FAIL underrun_slot%0d: got %02h required %02h", k, din_log[(en_cyc[0]+1+k) % 4096],
                   (k < 20) ? 8'(k) : 8'h00);
        end
      end
    end else begin
      n_checks++; n_fail++;
      $display("FAIL underrun_strobe: got %0d strobes required 1", en_cyc.size());
    end
    n_checks++;
    if (err_underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: got %0b required 1", err_underrun); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    sample();
    n_checks++;
    if (err_underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clr: got %0b required 0", err_underrun); end
    step();
  endtask

  task automatic test_tx_overflow();
    int t = 0;
    do_reset(); clear_logs();
    send_byte(8'h08);
    repeat (10) step();
    sample();
    n_checks++;
    if (idle !== 1'b0) begin n_fail++; $display("FAIL tx_busy_idle: got %0b required 0", idle); end
    while (core_busy && t < 500) begin sample(); t++; end
    n_checks++;
    if (idle !== 1'b0) begin n_fail++; $display("FAIL tx_fall_idle: got %0b required 0", idle); end
    step(); sample();
    n_checks++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL tx_return_idle: got %0b required 1", idle); end
    n_checks++;
    if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL tx_overflow: got %0b required 1", err_overflow); end
    n_checks++;
    if (en_op.size() != 1 || en_op[0] !== OP_IMG_TX) begin
      n_fail++; $display("FAIL tx_strobe: got %0d strobes required 1 IMG_TX", en_op.size());
    end
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== tx_pix(k)) begin
        n_fail++; $display("FAIL tx_byte%0d: got valid %0b data %02h required 1 %02h", k, m_valid, m_data, tx_pix(k));
      end
      step(); m_ready = 1'b1; step(); m_ready = 1'b0;
      sample();
    end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: m_valid=%0b required 0", m_valid); end
    step();
  endtask

  task automatic test_conv();
    int bad = 0;
    do_reset(); clear_logs();
    conv_busy = 1'b1;
    send_byte(8'h09);
    for (int i = 0; i < 200; i++) begin
      sample();
      if (s_ready !== 1'b0) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL conv_ready: %0d cycles with s_ready high required 0", bad); end
    n_checks++;
    if (en_op.size() != 1 || en_op[0] !== OP_CONV) begin
      n_fail++; $display("FAIL conv_strobe: got %0d strobes required 1 CONV", en_op.size());
    end
    conv_busy = 1'b0;
    sample();
    n_checks++;
    if (idle !== 1'b0) begin n_fail++; $display("FAIL conv_fall_idle: got %0b required 0", idle); end
    step(); sample();
    n_checks++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL conv_idle: got %0b required 1", idle); end
    step();
  endtask

  task automatic test_badcmd_zero_npix();
    do_reset(); clear_logs();
    send_byte(8'h3A); send_byte(8'h0B);
    sample();
    n_checks++;
    if (err_badcmd !== 1'b1) begin n_fail++; $display("FAIL badcmd_flag: got %0b required 1", err_badcmd); end
    n_checks++;
    if (en_op.size() != 0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL badcmd_quiet: got %0d strobes idle %0b required 0 1", en_op.size(), idle);
    end
    step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    sample();
    n_checks++;
    if (err_badcmd !== 1'b0) begin n_fail++; $display("FAIL badcmd_clr: got %0b required 0", err_badcmd); end
    step();
    err_clr = 1'b1;
    send_byte(8'h3A);
    err_clr = 1'b0;
    sample();
    n_checks++;
    if (err_badcmd !== 1'b1) begin n_fail++; $display("FAIL badcmd_set_priority: got %0b required 1", err_badcmd); end
    step();
    err_clr = 1'b1; step(); err_clr = 1'b0;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h07); send_byte(8'h08);
    step(); step(); step();
    sample();
    n_checks++;
    if (en_op.size() != 1 || en_op[0] !== OP_SET_NROWS) begin
      n_fail++; $display("FAIL zero_npix: got %0d strobes required 1 SET_NROWS", en_op.size());
    end
    n_checks++;
    if (idle !== 1'b1 || err_badcmd !== 1'b0) begin
      n_fail++; $display("FAIL zero_npix_idle: got idle %0b badcmd %0b required 1 0", idle, err_badcmd);
    end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_set_get();
    test_rx_full();
    test_rx_underrun();
    test_tx_overflow();
    test_conv();
    test_badcmd_zero_npix();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
